add_seq: RTL and testbench
==========================

Name: add_seq

Overview:
- Parametrised multi-cycle successor to the combinational 16-bit adder.
- Adds or subtracts two WIDTH-bit operands one CHUNK-bit slice per clock, least-significant slice first, propagating carry between slices.
- Valid/ready handshake on input and output, so it sits between a register-file read port and a writeback stage without a wide carry chain in one cycle.

Parameters:
- WIDTH, 32, operand and result width; must be a multiple of CHUNK.
- CHUNK, 16, bits added per clock; must satisfy 1 <= CHUNK <= WIDTH.
- NCHUNK = WIDTH/CHUNK is derived (localparam, not overridable).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in; ignored when sub=1.
- sub  in  1  0 = a+b+cin, 1 = a-b.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result.
- cout  out  1  carry out of MSB; for subtraction, 1 means no borrow.
- overflow  out  1  signed two's-complement overflow.

Behaviour:
- Reset, applied while rst_n=0 at a clock edge:
  - state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, overflow=0, slice index=0.
  - Reset mid-operation aborts the operation with no output.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, latch a and b_eff = sub ? ~b : b, set carry = sub ? 1 : cin, set index=0, go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle compute {c, s} = a[idx slice] + b_eff[idx slice] + carry, write s into sum[idx slice], set carry=c, idx++.
  - On the slice with idx==NCHUNK-1, also set cout=c and overflow = (a[MSB]==b_eff[MSB]) && (s[MSB]!=a[MSB]), then go to DONE.
- DONE:
  - out_valid=1; sum, cout and overflow are held stable.
  - On out_ready, go to IDLE: out_valid=0 next cycle, sum holds its last value.
- Timing:
  - Latency: accept at edge k, out_valid=1 after edge k+NCHUNK.
  - Throughput: one result per NCHUNK+2 cycles with out_ready held high.
  - in_ready and out_valid are never both 1.
- Boundary cases:
  - sum is not valid while RUN is in progress (partial slices are visible); consumers use out_valid only.
  - Operand changes after acceptance have no effect.
  - in_valid while busy is ignored, and the source must hold it.
  - out_ready while out_valid=0 has no effect.
  - Arithmetic wraps modulo 2^WIDTH; cout and overflow report the wrap.
  - NCHUNK=1 (CHUNK=WIDTH) is legal: one RUN cycle.

Optional Feature:
- Macro: ADD_SEQ_SAT_EN.
- When defined, overflow=1 replaces sum in DONE with signed saturation: 0x7F..F if a[MSB]=0, else 0x80..0. cout is unchanged and overflow still reports 1.
- When undefined, sum is the wrapped result only; no saturation logic is synthesised.

Test Plan (WIDTH=32, CHUNK=16):
- Carry across slices: a=0x0000FFFF, b=0x00000001, cin=0, sub=0 → sum=0x00010000, cout=0, overflow=0. out_valid rises exactly 2 edges after acceptance.
- Full wrap: a=0xFFFFFFFF, b=0x00000001 → sum=0x00000000, cout=1, overflow=0. With cin=1 and a=b=0xFFFFFFFF → sum=0xFFFFFFFF, cout=1.
- Subtract: a=3, b=3, sub=1 → sum=0, cout=1. a=0, b=1, sub=1 → sum=0xFFFFFFFF, cout=0. cin=1 has no effect in either case.
- Signed overflow: a=0x7FFFFFFF, b=1 → sum=0x80000000, overflow=1. With ADD_SEQ_SAT_EN defined → sum=0x7FFFFFFF, overflow=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → out_valid, sum, cout and overflow stay stable and in_ready=0. A new in_valid during that time is not accepted until after out_ready is asserted and the block returns to IDLE.
- Reset mid-operation: drive rst_n=0 for one edge during RUN → next cycle in_ready=1, out_valid=0, sum=0. The next operation, a=0x0000FFFF with b=0x0000FFFF, gives sum=0x0001FFFE.

Source files
------------

// File: rtl/add_seq.sv
// rtl/add_seq.sv - multi-cycle sliced adder/subtractor with valid/ready handshake
// Optional signed saturation on overflow: define ADD_SEQ_SAT_EN.
module add_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [CHUNK-1:0] a_sl, b_sl;
  logic [CHUNK:0]   slice_add;
  logic             slice_ovf;

  assign a_sl      = a_q[int'(idx_q)*CHUNK +: CHUNK];
  assign b_sl      = b_q[int'(idx_q)*CHUNK +: CHUNK];
  assign slice_add = {1'b0, a_sl} + {1'b0, b_sl} + (CHUNK+1)'(carry_q);
  // Only meaningful on the top slice, where the slice MSB is the word MSB.
  assign slice_ovf = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                     (slice_add[CHUNK-1] != a_q[WIDTH-1]);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          idx_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        sum_d[int'(idx_q)*CHUNK +: CHUNK] = slice_add[CHUNK-1:0];
        carry_d = slice_add[CHUNK];
        if (idx_q == LAST_IDX) begin
          cout_d  = slice_add[CHUNK];
          ovf_d   = slice_ovf;
          idx_d   = '0;
          state_d = S_DONE;
`ifdef ADD_SEQ_SAT_EN
          if (slice_ovf) begin
            sum_d = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                 : {1'b0, {(WIDTH-1){1'b1}}};
          end
`else
`endif
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_add_seq.sv
// tb/tb_add_seq.sv - directed vector bench for add_seq (WIDTH=32, CHUNK=16)
module tb_add_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic        cin, sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic        cout, overflow;

  int checks = 0;
  int failures = 0;

  add_seq #(.WIDTH(32), .CHUNK(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Handshake exclusivity is checked on every falling edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      checks++;
      if (in_ready && out_valid) begin
        failures++;
        $display("FAIL ready_valid_exclusive actual=1 required=0");
      end
    end
  end

  function automatic logic [31:0] sat_exp(input logic [31:0] s, input logic ovf, input logic [31:0] aa);
`ifdef ADD_SEQ_SAT_EN
    if (ovf) return aa[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`else
`endif
    return s;
  endfunction

  // Present operands one negedge before the accepting edge, scramble them after.
  task automatic start_op(input logic [31:0] ta, input logic [31:0] tb, input logic tcin, input logic tsub);
    @(negedge clk);
    a = ta; b = tb; cin = tcin; sub = tsub; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = ~ta; b = ~tb; cin = ~tcin; sub = ~tsub;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_valid) begin
      failures++;
      checks++;
      $display("FAIL wait_done_timeout actual=%0d required=2", lat);
    end
  endtask

  initial begin
    int lat;
    logic [31:0] hold_sum;
    logic        hold_cout, hold_ovf;

    vecs[0]  = '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0};
    vecs[1]  = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    vecs[2]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0};
    vecs[3]  = '{32'h0000_0003, 32'h0000_0003, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
    vecs[4]  = '{32'h0000_0003, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
    vecs[5]  = '{32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0};
    vecs[6]  = '{32'h0000_0000, 32'h0000_0001, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0};
    vecs[7]  = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    vecs[8]  = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
    vecs[9]  = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
    vecs[10] = '{32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0, 32'hACF1_3569, 1'b0, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_sum", sum, 32'h0);
    chk("reset_cout", 32'(cout), 32'd0);
    chk("reset_ovf", 32'(overflow), 32'd0);
    rst_n = 1'b1;

    // out_ready held high throughout: it must not matter before out_valid.
    out_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub);
      wait_done(lat);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'd2);
      chk($sformatf("v%0d_sum", i), sum, sat_exp(vecs[i].sum, vecs[i].ovf, vecs[i].a));
      chk($sformatf("v%0d_cout", i), 32'(cout), 32'(vecs[i].cout));
      chk($sformatf("v%0d_ovf", i), 32'(overflow), 32'(vecs[i].ovf));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_release_valid", i), 32'(out_valid), 32'd0);
      chk($sformatf("v%0d_release_ready", i), 32'(in_ready), 32'd1);
      chk($sformatf("v%0d_sum_hold", i), sum, sat_exp(vecs[i].sum, vecs[i].ovf, vecs[i].a));
    end

    // Backpressure: result held for 5 cycles while a new request waits.
    out_ready = 1'b0;
    start_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    wait_done(lat);
    hold_sum = sum; hold_cout = cout; hold_ovf = overflow;
    chk("bp_sum", hold_sum, sat_exp(32'h8000_0000, 1'b1, 32'h7FFF_FFFF));
    a = 32'h0000_FFFF; b = 32'h0000_FFFF; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("bp%0d_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("bp%0d_in_ready", i), 32'(in_ready), 32'd0);
      chk($sformatf("bp%0d_sum", i), sum, hold_sum);
      chk($sformatf("bp%0d_cout", i), 32'(cout), 32'(hold_cout));
      chk($sformatf("bp%0d_ovf", i), 32'(overflow), 32'(hold_ovf));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("bp_release_valid", 32'(out_valid), 32'd0);
    chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp_accept_in_ready", 32'(in_ready), 32'd0);
    wait_done(lat);
    chk("bp_next_latency", 32'(lat), 32'd2);
    chk("bp_next_sum", sum, 32'h0001_FFFE);
    chk("bp_next_cout", 32'(cout), 32'd0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;

    // Reset during RUN aborts the operation.
    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_sum", sum, 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_no_output", 32'(out_valid), 32'd0);
    start_op(32'h0000_FFFF, 32'h0000_FFFF, 1'b0, 1'b0);
    wait_done(lat);
    chk("post_rst_latency", 32'(lat), 32'd2);
    chk("post_rst_sum", sum, 32'h0001_FFFE);
    chk("post_rst_ovf", 32'(overflow), 32'd0);
    @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
